// File: rtl/main_mem_responder_pkg.sv
// Shared constants and FSM encoding for the main-memory responder and its cache client.
package main_mem_responder_pkg;

    localparam int DEF_BLOCK_WORDS = 4;
    localparam int DEF_MEM_WORDS   = 4096;
    localparam int DEF_LATENCY     = 4;
    localparam int LAT_CW          = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAT    = 3'd1,
        ST_RBURST = 3'd2,
        ST_WBURST = 3'd3,
        ST_WDONE  = 3'd4
    } mm_state_e;

endpackage

// File: rtl/main_mem_responder_mem_word_array.sv
// Word storage: one combinational read port, one synchronous write port, never cleared.
module mem_word_array #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/main_mem_responder.sv
// Block-burst main memory model for a cache: refills after LATENCY cycles, accepts writebacks.
// Optional macro MAIN_MEM_CRITICAL_WORD_FIRST_EN starts refills at the requested word.
module main_mem_responder
    import main_mem_responder_pkg::*;
#(
    parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
    parameter int MEM_WORDS   = DEF_MEM_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] wdata,
    input  logic        wvalid,
    output logic        wready,
    output logic        wdone,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        rready,
    output logic        rlast
);

    localparam int OW = $clog2(BLOCK_WORDS);
    localparam int AW = $clog2(MEM_WORDS);

    mm_state_e          r_state, w_state_nxt;
    logic [LAT_CW-1:0]  r_cnt, w_cnt_nxt;
    logic [OW-1:0]      r_beat, w_beat_nxt;
    logic [OW-1:0]      r_start, w_start_nxt;
    logic [AW-1:0]      r_base, w_base_nxt;

    logic [AW-1:0]      w_word;
    logic [OW-1:0]      w_roff;
    logic [AW-1:0]      w_raddr, w_waddr;
    logic [31:0]        w_mem_rdata;
    logic               w_we;
    logic               w_last_beat;
    logic               w_unused_addr;

    // Modulo MEM_WORDS falls out of dropping the high address bits.
    assign w_word        = req_addr[AW+1:2];
    assign w_unused_addr = &{1'b0, req_addr[31:AW+2], req_addr[1:0]};

    assign w_last_beat = (r_beat == OW'(BLOCK_WORDS - 1));
    assign w_roff      = r_start + r_beat;
    assign w_raddr     = r_base | AW'(w_roff);
    assign w_waddr     = r_base | AW'(r_beat);
    assign w_we        = reset && (r_state == ST_WBURST) && wvalid;

    mem_word_array #(.DEPTH(MEM_WORDS), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_rdata)
    );

    // Storage cannot change during a refill, so rdata stays stable while stalled.
    assign rdata = (r_state == ST_RBURST) ? w_mem_rdata : 32'd0;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_beat_nxt  = r_beat;
        w_start_nxt = r_start;
        w_base_nxt  = r_base;
        req_ready   = 1'b0;
        wready      = 1'b0;
        wdone       = 1'b0;
        rvalid      = 1'b0;
        rlast       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_base_nxt = w_word & ~AW'(BLOCK_WORDS - 1);
                    w_beat_nxt = '0;
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
                    w_start_nxt = req_write ? '0 : w_word[OW-1:0];
`else
                    w_start_nxt = '0;
`endif
                    if (req_write) begin
                        w_state_nxt = ST_WBURST;
                    end else if (LATENCY == 1) begin
                        w_state_nxt = ST_RBURST;
                    end else begin
                        w_state_nxt = ST_LAT;
                        w_cnt_nxt   = LAT_CW'(LATENCY - 1);
                    end
                end
            end
            ST_LAT: begin
                // Counter hits 0 on the same edge that enters RBURST: first beat at T+LATENCY.
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= LAT_CW'(1)) begin
                    w_state_nxt = ST_RBURST;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RBURST: begin
                rvalid = 1'b1;
                rlast  = w_last_beat;
                if (rready) begin
                    w_beat_nxt = r_beat + 1'b1;
                    if (w_last_beat)
                        w_state_nxt = ST_IDLE;
                end
            end
            ST_WBURST: begin
                wready = 1'b1;
                if (wvalid) begin
                    w_beat_nxt = r_beat + 1'b1;
                    if (w_last_beat)
                        w_state_nxt = ST_WDONE;
                end
            end
            ST_WDONE: begin
                wdone       = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_start <= '0;
            r_base  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_beat  <= w_beat_nxt;
            r_start <= w_start_nxt;
            r_base  <= w_base_nxt;
        end
    end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed plus randomized bench for main_mem_responder against a word-array reference model.
module tb_main_mem_responder;

    localparam int BW  = 4;
    localparam int MW  = 4096;
    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, wdata, rdata;
    logic        wvalid, wready, wdone, rvalid, rready, rlast;

    int total = 0;
    int bad   = 0;

    logic [31:0] mm   [MW];
    logic [31:0] wbuf [BW];

    main_mem_responder #(.BLOCK_WORDS(BW), .MEM_WORDS(MW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_addr(req_addr),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wdone(wdone),
        .rdata(rdata), .rvalid(rvalid), .rready(rready), .rlast(rlast)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % MW);
    endfunction

    function automatic int wbase(input logic [31:0] a);
        return widx(a) - (widx(a) % BW);
    endfunction

    task automatic do_write(input logic [31:0] addr, input int maxgap);
        int base;
        base = wbase(addr);
        chk("wr_req_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = addr;
        cyc();
        req_valid = 1'b0; req_write = 1'b0; req_addr = $urandom;
        chk("wr_req_ready_busy", req_ready, 0);
        for (int i = 0; i < BW; i++) begin
            int gaps;
            gaps = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                wvalid = 1'b0; wdata = $urandom;
                chk("wr_wready_gap", wready, 1);
                cyc();
            end
            wvalid = 1'b1; wdata = wbuf[i];
            chk("wr_wready", wready, 1);
            chk("wr_wdone_early", wdone, 0);
            cyc();
        end
        wvalid = 1'b0;
        chk("wr_wdone", wdone, 1);
        chk("wr_wready_done", wready, 0);
        for (int i = 0; i < BW; i++) mm[base + i] = wbuf[i];
        cyc();
        chk("wr_wdone_once", wdone, 0);
        chk("wr_req_ready_back", req_ready, 1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int stall_beat, input int stall_n, input bit rnd);
        int base, start;
        logic [31:0] exp;
        base = wbase(addr);
`ifdef MAIN_MEM_CRITICAL_WORD_FIRST_EN
        start = widx(addr) % BW;
`else
        start = 0;
`endif
        chk("rd_req_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; rready = 1'b0;
        cyc();
        req_valid = 1'b0; req_addr = $urandom;
        chk("rd_req_ready_busy", req_ready, 0);
        for (int k = 1; k < LAT; k++) begin
            chk("rd_rvalid_lat", rvalid, 0);
            wvalid = 1'b1; wdata = $urandom;
            cyc();
        end
        wvalid = 1'b0;
        for (int i = 0; i < BW; i++) begin
            int s;
            exp = mm[base + ((start + i) % BW)];
            s = rnd ? int'($urandom_range(0, 2)) : ((i == stall_beat) ? stall_n : 0);
            for (int j = 0; j < s; j++) begin
                rready = 1'b0;
                chk("rd_rvalid_hold", rvalid, 1);
                chk("rd_rdata_hold", rdata, exp);
                chk("rd_rlast_hold", rlast, (i == BW - 1) ? 1 : 0);
                cyc();
            end
            rready = 1'b1;
            chk("rd_rvalid", rvalid, 1);
            chk("rd_rdata", rdata, exp);
            chk("rd_rlast", rlast, (i == BW - 1) ? 1 : 0);
            cyc();
        end
        rready = 1'b0;
        chk("rd_rvalid_end", rvalid, 0);
        chk("rd_rlast_end", rlast, 0);
        chk("rd_req_ready_end", req_ready, 1);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        wdata = '0; wvalid = 1'b0; rready = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_wready", wready, 0);
        chk("rst_wdone", wdone, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1'b1;
        cyc();
        chk("rst_req_ready", req_ready, 1);

        // Block 0x100 gets A0..A3, beats back to back.
        for (int i = 0; i < BW; i++) wbuf[i] = 32'hA0 + i;
        do_write(32'h100, 0);

        // Stray writeback beats while idle must not land anywhere.
        wvalid = 1'b1; wdata = 32'hDEAD_BEEF;
        cyc(); cyc();
        wvalid = 1'b0;

        do_read(32'h100, -1, 0, 1'b0);
        do_read(32'h100, 1, 3, 1'b0);
        do_read(32'h108, -1, 0, 1'b0);
        do_read(32'(MW * 4 + 32'h100), -1, 0, 1'b0);

        // Reset after two beats of a writeback: beats stored so far survive, no wdone.
        chk("mid_req_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100;
        cyc();
        req_valid = 1'b0; req_write = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wvalid = 1'b1; wdata = 32'hB0 + i;
            cyc();
            mm[wbase(32'h100) + i] = 32'hB0 + i;
        end
        wvalid = 1'b0; reset = 1'b0;
        cyc();
        chk("mid_wready", wready, 0);
        chk("mid_wdone", wdone, 0);
        chk("mid_rvalid", rvalid, 0);
        chk("mid_rlast", rlast, 0);
        chk("mid_rdata", rdata, 0);
        reset = 1'b1;
        cyc();
        chk("mid_wdone_after", wdone, 0);
        chk("mid_req_ready_after", req_ready, 1);
        do_read(32'h100, -1, 0, 1'b0);

        // Randomized traffic over eight blocks, with aliased and misaligned addresses.
        for (int b = 0; b < 8; b++) begin
            for (int i = 0; i < BW; i++) wbuf[i] = $urandom;
            do_write(32'((32'h200 + b * BW) * 4), 2);
        end
        for (int n = 0; n < 24; n++) begin
            logic [31:0] a;
            a = 32'((32'h200 + $urandom_range(0, 7) * BW + $urandom_range(0, BW - 1)) * 4)
                + 32'($urandom_range(0, 3)) + 32'($urandom_range(0, 3) * MW * 4);
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < BW; i++) wbuf[i] = $urandom;
                do_write(a, 2);
            end else begin
                do_read(a, -1, 0, 1'b1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 4, words per cache block (power of two, 2..16).
REQ-002 SHALL have parameter MEM_WORDS, default 4096, backing storage depth in 32-bit words (power of two).
REQ-003 SHALL have parameter LATENCY, default 4, cycles from request acceptance to first read beat (1..15).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge).
REQ-006 req_valid  input  1  cache presents a block request.
REQ-007 req_ready  output  1  responder accepts request this cycle.
REQ-008 req_write  input  1  1 = block writeback, 0 = block refill.
REQ-009 req_addr  input  32  byte address; bits [1:0] ignored.
REQ-010 wdata  input  32  writeback data beat.
REQ-011 wvalid  input  1  writeback beat valid.
REQ-012 wready  output  1  responder accepts writeback beat.
REQ-013 wdone  output  1  one-cycle pulse after final writeback beat stored.
REQ-014 rdata  output  32  refill data beat.
REQ-015 rvalid  output  1  refill beat valid.
REQ-016 rready  input  1  cache accepts refill beat.
REQ-017 rlast  output  1  marks final refill beat; high only with rvalid.

Function
REQ-018 SHALL implement FSM states IDLE, LAT, RBURST, WBURST, WDONE.
REQ-019 req_ready SHALL be 1 only in IDLE; handshake = req_valid & req_ready.
REQ-020 On handshake SHALL latch req_addr, req_write; block base = word address with low log2(BLOCK_WORDS) bits cleared.
REQ-021 Word index SHALL be word address modulo MEM_WORDS; out-of-range addresses alias, no error.
REQ-022 Read handshake: IDLE->LAT, counter loaded LATENCY-1; LAT->RBURST when counter reaches 0; first rvalid exactly LATENCY cycles after handshake cycle.
REQ-023 RBURST: rvalid=1 with rdata held stable until rvalid&rready; beat counter advances only on that transfer.
REQ-024 RBURST SHALL emit exactly BLOCK_WORDS beats; rlast on final beat; after its transfer -> IDLE.
REQ-025 Write handshake: IDLE->WBURST; wready=1 throughout WBURST; each wvalid&wready stores wdata to next word, beat offsets 0..BLOCK_WORDS-1 from block base.
REQ-026 After final write beat -> WDONE; wdone=1 for exactly that one cycle; WDONE->IDLE.
REQ-027 wvalid outside WBURST SHALL be ignored; storage unchanged.
REQ-028 A read of a block SHALL return data from any writeback of that block completed (wdone) earlier.
REQ-029 Beat offsets SHALL wrap modulo BLOCK_WORDS within the block, never crossing into the adjacent block.
REQ-030 Back-to-back requests: earliest next acceptance SHALL be the cycle after return to IDLE.

Reset
REQ-031 On reset: state IDLE, counters 0, req_ready 1 after release; wready, wdone, rvalid, rlast 0; rdata 0.
REQ-032 Reset mid-burst SHALL abort the transaction; words already stored stay stored; no further beats or wdone.
REQ-033 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-034 Macro MAIN_MEM_CRITICAL_WORD_FIRST_EN defined: read burst SHALL start at offset req_addr word-in-block and wrap (e.g. 2,3,0,1); rlast on the BLOCK_WORDSth beat.
REQ-035 Macro undefined: read burst SHALL always start at offset 0 regardless of req_addr low bits; write order always from offset 0 in both builds.

Structure
REQ-036 Shared package SHALL hold FSM state encoding and default BLOCK_WORDS/MEM_WORDS/LATENCY constants, shared with the cache.
REQ-037 Storage array SHALL be a separate sub-module mem_word_array (1 read port, 1 write port, synchronous write, combinational read).

Verification
REQ-038 Write block 0x100 with 0xA0..0xA3 -> wready high 4 cycles, wdone pulses once cycle after 4th beat; read 0x100 -> 0xA0,0xA1,0xA2,0xA3, rlast on 0xA3.
REQ-039 Read accepted cycle T, LATENCY=4, rready=1 -> rvalid first high at T+4, beats on T+4..T+7, req_ready high again T+8.
REQ-040 rready low 3 cycles on beat 1 -> rdata/rvalid held constant, no beat skipped or duplicated.
REQ-041 With MAIN_MEM_CRITICAL_WORD_FIRST_EN, read 0x108 after REQ-038 data -> 0xA2,0xA3,0xA0,0xA1; without macro -> 0xA0..0xA3.
REQ-042 Assert reset=0 after 2 write beats -> all outputs reset values next cycle, no wdone; words 0,1 updated, 2,3 unchanged.
REQ-043 Read address MEM_WORDS*4+0x100 -> same data as 0x100 (alias).
